// File: rtl/ctrl_seq.sv
// Multicycle control sequencer: fetch/decode/execute/memory/writeback with req/ack memory handshake,
// illegal-opcode trap and sticky halt. Define CTRL_MEM_TMO_EN to enable the memory wait-state timeout.
module ctrl_seq #(
    parameter int unsigned IW      = 36,
    parameter int unsigned OPW     = 5,
    parameter int unsigned RAW     = 5,
    parameter int unsigned INC_REG = 15,
    parameter int unsigned MEM_TMO = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IW-1:0]  instr,
    input  logic           z,
    input  logic           mem_ack,
    output logic           ir_load,
    output logic           pc_en,
    output logic [1:0]     pc_sel,
    output logic           mem_req,
    output logic           mem_we,
    output logic           addr_sel,
    output logic [1:0]     alu_op,
    output logic [RAW-1:0] rpa,
    output logic [RAW-1:0] rpb,
    output logic [RAW-1:0] wpn,
    output logic           write_en,
    output logic [1:0]     wb_sel,
    output logic           rf_clr,
    output logic [1:0]     fault,
    output logic           halted
);

    localparam int unsigned TW      = (MEM_TMO > 255) ? $clog2(MEM_TMO + 1) : 8;
    localparam int unsigned OP_NOP   = 0;
    localparam int unsigned OP_HALT  = 1;
    localparam int unsigned OP_RST   = 2;
    localparam int unsigned OP_WRITE = 3;
    localparam int unsigned OP_LOADI = 4;
    localparam int unsigned OP_MUL   = 5;
    localparam int unsigned OP_LOAD  = 6;
    localparam int unsigned OP_MV    = 7;
    localparam int unsigned OP_ADD   = 8;
    localparam int unsigned OP_INC   = 9;
    localparam int unsigned OP_SUB   = 10;
    localparam int unsigned OP_JMPZ  = 11;
    localparam int unsigned OP_JMP   = 12;
    localparam int unsigned OP_STORE = 13;

    // Three halt flavours keep the fault code in the state register itself.
    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MEM      = 3'd3,
        ST_WB       = 3'd4,
        ST_HALT     = 3'd5,
        ST_HALT_ILL = 3'd6,
        ST_HALT_TMO = 3'd7
    } state_e;

    state_e state_q, state_d, state_nxt;
    logic   tmo_c;

    logic [OPW-1:0] opc;
    logic [RAW-1:0] rd, rs_a, rs_b;
    logic [IW-1:0]  instr_unused;

    assign opc          = instr[OPW-1:0];
    assign rd           = instr[OPW +: RAW];
    assign rs_a         = instr[OPW+RAW +: RAW];
    assign rs_b         = instr[OPW+2*RAW +: RAW];
    assign instr_unused = instr >> (OPW + 3*RAW);

    // Operand/ALU selection shared by EXEC and WB, so WB holds the EXEC values.
    logic [RAW-1:0] ex_rpa, ex_rpb;
    logic [1:0]     ex_alu, ex_wb_sel;

    always_comb begin
        ex_rpa    = '0;
        ex_rpb    = '0;
        ex_alu    = 2'b00;
        ex_wb_sel = 2'b00;
        case (opc)
            OPW'(OP_ADD): begin
                ex_rpa = rs_a;
                ex_rpb = rs_b;
                ex_alu = 2'b01;
            end
            OPW'(OP_SUB): begin
                ex_rpa = rs_a;
                ex_rpb = rs_b;
                ex_alu = 2'b10;
            end
            OPW'(OP_MUL): begin
                ex_rpa = rs_a;
                ex_rpb = rs_b;
                ex_alu = 2'b11;
            end
            OPW'(OP_INC): begin
                ex_rpa = rd;
                ex_rpb = RAW'(INC_REG);
                ex_alu = 2'b01;
            end
            OPW'(OP_MV): begin
                ex_rpa    = rs_a;
                ex_wb_sel = 2'b11;
            end
            OPW'(OP_WRITE), OPW'(OP_LOADI): ex_wb_sel = 2'b10;
            OPW'(OP_LOAD):                  ex_wb_sel = 2'b01;
            default: ;
        endcase
    end

    // Next state and decoded outputs; everything is forced low while reset is asserted.
    always_comb begin
        state_nxt = state_q;
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 2'b00;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        alu_op    = 2'b00;
        rpa       = '0;
        rpb       = '0;
        wpn       = '0;
        write_en  = 1'b0;
        wb_sel    = 2'b00;
        rf_clr    = 1'b0;
        fault     = 2'b00;
        halted    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load   = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nxt = (opc > OPW'(OP_STORE)) ? ST_HALT_ILL : ST_EXEC;
            end
            ST_EXEC: begin
                rpa    = ex_rpa;
                rpb    = ex_rpb;
                alu_op = ex_alu;
                case (opc)
                    OPW'(OP_NOP):  state_nxt = ST_FETCH;
                    OPW'(OP_HALT): state_nxt = ST_HALT;
                    OPW'(OP_RST): begin
                        rf_clr    = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                    OPW'(OP_WRITE), OPW'(OP_LOADI), OPW'(OP_MUL), OPW'(OP_MV),
                    OPW'(OP_ADD), OPW'(OP_INC), OPW'(OP_SUB): state_nxt = ST_WB;
                    OPW'(OP_LOAD), OPW'(OP_STORE):            state_nxt = ST_MEM;
                    OPW'(OP_JMP): begin
                        pc_en     = 1'b1;
                        pc_sel    = 2'b01;
                        state_nxt = ST_FETCH;
                    end
                    OPW'(OP_JMPZ): begin
                        pc_en     = z;
                        pc_sel    = 2'b01;
                        state_nxt = ST_FETCH;
                    end
                    default: state_nxt = ST_HALT_ILL;
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                rpa      = rs_a;
                if (opc == OPW'(OP_STORE)) begin
                    mem_we = 1'b1;
                    rpb    = rd;
                end
                if (mem_ack) begin
                    state_nxt = (opc == OPW'(OP_LOAD)) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                write_en  = 1'b1;
                wpn       = rd;
                wb_sel    = ex_wb_sel;
                rpa       = ex_rpa;
                rpb       = ex_rpb;
                alu_op    = ex_alu;
                state_nxt = ST_FETCH;
            end
            ST_HALT:     halted = 1'b1;
            ST_HALT_ILL: begin
                halted = 1'b1;
                fault  = 2'b01;
            end
            ST_HALT_TMO: begin
                halted = 1'b1;
                fault  = 2'b10;
            end
            default: state_nxt = ST_FETCH;
        endcase

        if (!rst_n) begin
            ir_load  = 1'b0;
            pc_en    = 1'b0;
            pc_sel   = 2'b00;
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            alu_op   = 2'b00;
            rpa      = '0;
            rpb      = '0;
            wpn      = '0;
            write_en = 1'b0;
            wb_sel   = 2'b00;
            rf_clr   = 1'b0;
            fault    = 2'b00;
            halted   = 1'b0;
        end
    end

`ifdef CTRL_MEM_TMO_EN
    logic          req_raw;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign req_raw = (state_q == ST_FETCH) || (state_q == ST_MEM);

    // Counts unanswered request cycles; restarts whenever FETCH or MEM is entered.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_c     = 1'b0;
        if (req_raw && !mem_ack) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
            tmo_c     = (({1'b0, tmo_cnt_q} + (TW+1)'(1)) >= (TW+1)'(MEM_TMO));
        end
        if ((state_nxt != state_q) && ((state_nxt == ST_FETCH) || (state_nxt == ST_MEM))) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [TW-1:0] tmo_unused;

    assign tmo_c      = 1'b0;
    assign tmo_unused = TW'(MEM_TMO);
`endif

    assign state_d = tmo_c ? ST_HALT_TMO : state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomized bench for ctrl_seq: a per-instruction cycle schedule model predicts every output on every cycle.
module tb_ctrl_seq;

    localparam int TB_TMO = 4;
    localparam int K_NOP = 0, K_HALT = 1, K_RST = 2, K_WB = 3, K_LOAD = 4,
                   K_STORE = 5, K_JMP = 6, K_JMPZ = 7, K_ILL = 8;

    typedef struct packed {
        logic       ir_load;
        logic       pc_en;
        logic [1:0] pc_sel;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic [1:0] alu_op;
        logic [4:0] rpa;
        logic [4:0] rpb;
        logic [4:0] wpn;
        logic       write_en;
        logic [1:0] wb_sel;
        logic       rf_clr;
        logic [1:0] fault;
        logic       halted;
    } out_t;

    typedef logic [$bits(out_t)-1:0] ov_t;

    typedef struct {
        logic        ack;
        logic [35:0] ins;
        logic        zz;
        out_t        exp;
        logic        rst_after;
    } cyc_t;

    logic        clk, rst_n, z, mem_ack;
    logic [35:0] instr;
    logic        ir_load, pc_en, mem_req, mem_we, addr_sel, write_en, rf_clr, halted;
    logic [1:0]  pc_sel, alu_op, wb_sel, fault;
    logic [4:0]  rpa, rpb, wpn;

    int   n_chk  = 0;
    int   n_fail = 0;
    cyc_t cq[$];
    out_t obs[$];

    ctrl_seq #(
        .IW(36), .OPW(5), .RAW(5), .INC_REG(15), .MEM_TMO(TB_TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .z(z), .mem_ack(mem_ack),
        .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .alu_op(alu_op), .rpa(rpa),
        .rpb(rpb), .wpn(wpn), .write_en(write_en), .wb_sel(wb_sel),
        .rf_clr(rf_clr), .fault(fault), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic out_t sample();
        out_t o;
        o.ir_load  = ir_load;
        o.pc_en    = pc_en;
        o.pc_sel   = pc_sel;
        o.mem_req  = mem_req;
        o.mem_we   = mem_we;
        o.addr_sel = addr_sel;
        o.alu_op   = alu_op;
        o.rpa      = rpa;
        o.rpb      = rpb;
        o.wpn      = wpn;
        o.write_en = write_en;
        o.wb_sel   = wb_sel;
        o.rf_clr   = rf_clr;
        o.fault    = fault;
        o.halted   = halted;
        return o;
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        ov_t a, e;
        a = act;
        e = exp;
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: actual %h required %h", name, $time, a, e);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic ack, input out_t e, input logic [35:0] ins,
                                 input logic zz, input logic ra);
        cyc_t c;
        c.ack       = ack;
        c.exp       = e;
        c.ins       = ins;
        c.zz        = zz;
        c.rst_after = ra;
        cq.push_back(c);
    endfunction

    // What each opcode asks of the datapath, straight from the opcode table.
    function automatic void op_info(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] rsa,
                                    input logic [4:0] rsb, output int kind, output logic [4:0] a,
                                    output logic [4:0] b, output logic [1:0] alu, output logic [1:0] wbs);
        kind = K_ILL;
        a    = '0;
        b    = '0;
        alu  = 2'b00;
        wbs  = 2'b00;
        case (opc)
            5'h0: kind = K_NOP;
            5'h1: kind = K_HALT;
            5'h2: kind = K_RST;
            5'h3, 5'h4: begin kind = K_WB; wbs = 2'b10; end
            5'h5: begin kind = K_WB; a = rsa; b = rsb; alu = 2'b11; end
            5'h8: begin kind = K_WB; a = rsa; b = rsb; alu = 2'b01; end
            5'hA: begin kind = K_WB; a = rsa; b = rsb; alu = 2'b10; end
            5'h9: begin kind = K_WB; a = rd; b = 5'd15; alu = 2'b01; end
            5'h7: begin kind = K_WB; a = rsa; wbs = 2'b11; end
            5'h6: begin kind = K_LOAD; wbs = 2'b01; end
            5'hD: kind = K_STORE;
            5'hC: kind = K_JMP;
            5'hB: kind = K_JMPZ;
            default: kind = K_ILL;
        endcase
    endfunction

    function automatic void halt_cycles(input logic [1:0] f, input logic [35:0] ins, input logic zz);
        out_t e;
        for (int i = 0; i < 3; i++) begin
            e        = '0;
            e.halted = 1'b1;
            e.fault  = f;
            push(rnd_bit(), e, ins, zz, (i == 2));
        end
    endfunction

    // Expected cycle-by-cycle schedule for one instruction; wf/wm are wait states, wm<0 means no ack.
    function automatic void gen(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] rsa,
                                input logic [4:0] rsb, input logic zz, input int wf, input int wm);
        logic [35:0] ins;
        out_t        e;
        int          kind;
        logic [4:0]  xa, xb;
        logic [1:0]  xalu, xwb;
        ins = {16'($urandom), rsb, rsa, rd, opc};
        op_info(opc, rd, rsa, rsb, kind, xa, xb, xalu, xwb);
        for (int i = 0; i < wf; i++) begin
            e = '0;
            e.mem_req = 1'b1;
            push(1'b0, e, ins, zz, 1'b0);
        end
        e = '0;
        e.mem_req = 1'b1;
        e.ir_load = 1'b1;
        e.pc_en   = 1'b1;
        push(1'b1, e, ins, zz, 1'b0);
        push(rnd_bit(), '0, ins, zz, 1'b0);
        if (kind == K_ILL) begin
            halt_cycles(2'b01, ins, zz);
            return;
        end
        e        = '0;
        e.rpa    = xa;
        e.rpb    = xb;
        e.alu_op = xalu;
        if (kind == K_RST) e.rf_clr = 1'b1;
        if (kind == K_JMP || kind == K_JMPZ) begin
            e.pc_en  = (kind == K_JMP) ? 1'b1 : zz;
            e.pc_sel = 2'b01;
        end
        push(rnd_bit(), e, ins, zz, 1'b0);
        if (kind == K_HALT) begin
            halt_cycles(2'b00, ins, zz);
            return;
        end
        if (kind == K_LOAD || kind == K_STORE) begin
            e          = '0;
            e.mem_req  = 1'b1;
            e.addr_sel = 1'b1;
            e.rpa      = rsa;
            if (kind == K_STORE) begin
                e.mem_we = 1'b1;
                e.rpb    = rd;
            end
            if (wm < 0) begin
                for (int i = 0; i < TB_TMO; i++) push(1'b0, e, ins, zz, 1'b0);
                halt_cycles(2'b10, ins, zz);
                return;
            end
            for (int i = 0; i < wm; i++) push(1'b0, e, ins, zz, 1'b0);
            push(1'b1, e, ins, zz, 1'b0);
        end
        if (kind == K_WB || kind == K_LOAD) begin
            e          = '0;
            e.write_en = 1'b1;
            e.wpn      = rd;
            e.wb_sel   = xwb;
            e.rpa      = xa;
            e.rpb      = xb;
            e.alu_op   = xalu;
            push(rnd_bit(), e, ins, zz, 1'b0);
        end
    endfunction

    task automatic pulse_reset();
        #1;
        rst_n   = 1'b0;
        mem_ack = 1'b1;
        #1;
        check_out("reset_async", sample(), '0);
        @(posedge clk);
        #1;
        check_out("reset_hold", sample(), '0);
        mem_ack = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Single compare process: drive each scheduled cycle at negedge, check the outputs 1ns later.
    task automatic run_queue();
        cyc_t c;
        out_t act;
        while (cq.size() > 0) begin
            c = cq.pop_front();
            @(negedge clk);
            mem_ack = c.ack;
            instr   = c.ins;
            z       = c.zz;
            #1;
            act = sample();
            obs.push_back(act);
            check_out("cycle", act, c.exp);
            if (c.rst_after) pulse_reset();
        end
    endtask

    initial begin
        int   base;
        cyc_t c;
        int   hold;
        rst_n   = 1'b0;
        mem_ack = 1'b0;
        instr   = '0;
        z       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", sample(), '0);
        #1;
        rst_n = 1'b1;

        // ADD rd=3 rs_a=1 rs_b=2, zero-wait fetch
        base = obs.size();
        gen(5'h8, 5'd3, 5'd1, 5'd2, 1'b0, 0, 0);
        gen(5'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0);
        run_queue();
        check_val("t1_exec_alu_op", int'(obs[base+2].alu_op), 1);
        check_val("t1_exec_rpb", int'(obs[base+2].rpb), 2);
        check_val("t1_wb_write_en", int'(obs[base+3].write_en), 1);
        check_val("t1_wb_wpn", int'(obs[base+3].wpn), 3);
        check_val("t1_wb_sel", int'(obs[base+3].wb_sel), 0);
        check_val("t1_next_fetch_req", int'(obs[base+4].mem_req), 1);

        // LOAD rd=4 rs_a=6 with 3 MEM wait states
        base = obs.size();
        gen(5'h6, 5'd4, 5'd6, 5'd9, 1'b0, 0, 3);
        run_queue();
        hold = 0;
        for (int i = 3; i < 7; i++) hold += int'(obs[base+i].mem_req & obs[base+i].addr_sel);
        check_val("t2_mem_hold_cycles", hold, 4);
        check_val("t2_wb_wpn", int'(obs[base+7].wpn), 4);
        check_val("t2_wb_sel", int'(obs[base+7].wb_sel), 1);
        check_val("t2_wb_req_low", int'(obs[base+7].mem_req), 0);

        // JMPZ not taken, then taken
        base = obs.size();
        gen(5'hB, 5'd1, 5'd2, 5'd3, 1'b0, 1, 0);
        gen(5'hB, 5'd1, 5'd2, 5'd3, 1'b1, 0, 0);
        gen(5'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0);
        run_queue();
        check_val("t3_z0_pc_en", int'(obs[base+3].pc_en), 0);
        check_val("t3_z0_pc_sel", int'(obs[base+3].pc_sel), 1);
        check_val("t3_z1_pc_en", int'(obs[base+6].pc_en), 1);
        check_val("t3_z1_pc_sel", int'(obs[base+6].pc_sel), 1);
        check_val("t3_back_to_fetch", int'(obs[base+7].mem_req), 1);

        // Illegal opcode 0x1F traps and halts until reset
        base = obs.size();
        gen(5'h1F, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0);
        gen(5'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0);
        run_queue();
        check_val("t4_fault", int'(obs[base+2].fault), 1);
        check_val("t4_halted", int'(obs[base+2].halted), 1);
        check_val("t4_halt_no_req", int'(obs[base+4].mem_req), 0);
        check_val("t4_fetch_after_reset", int'(obs[base+5].mem_req), 1);

        // Reset in the middle of a STORE MEM wait
        base = obs.size();
        gen(5'hD, 5'd7, 5'd2, 5'd0, 1'b0, 0, 5);
        while (cq.size() > 5) void'(cq.pop_back());
        c = cq.pop_back();
        c.rst_after = 1'b1;
        cq.push_back(c);
        gen(5'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0);
        run_queue();
        check_val("t5_store_we_before_reset", int'(obs[base+4].mem_we), 1);
        check_val("t5_store_rpb", int'(obs[base+4].rpb), 7);
        check_val("t5_fetch_resumes", int'(obs[base+5].mem_req), 1);

`ifdef CTRL_MEM_TMO_EN
        // STORE with no ack times out after TB_TMO wait cycles
        base = obs.size();
        gen(5'hD, 5'd1, 5'd2, 5'd0, 1'b0, 0, -1);
        gen(5'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0);
        run_queue();
        check_val("t6_last_wait_req", int'(obs[base+2+TB_TMO].mem_req), 1);
        check_val("t6_fault", int'(obs[base+3+TB_TMO].fault), 2);
        check_val("t6_halted", int'(obs[base+3+TB_TMO].halted), 1);
`endif

        for (int t = 0; t < 250; t++) begin
            logic [4:0] opc;
            if ($urandom_range(0, 19) == 0) opc = 5'($urandom_range(14, 31));
            else                            opc = 5'($urandom_range(0, 13));
            gen(opc, 5'($urandom), 5'($urandom), 5'($urandom), rnd_bit(),
                $urandom_range(0, 3), $urandom_range(0, 3));
            run_queue();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
